// File: rtl/load_store_unit.sv
// Load/store unit: serialises word/half/byte accesses into little-endian byte
// accesses on a byte-wide synchronous memory and returns a one-cycle response.
module load_store_unit #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        AU_inst_sel,
  input  logic              signed_inst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata;
  logic [1:0]        r_idx, w_idx_nxt, w_idx_inc, w_last_idx;
  logic              r_cap_en;
  logic [1:0]        r_cap_idx;
  logic [31:0]       r_rdata;

  logic              w_accept, w_req_err;
  logic              w_mem_en_nxt, w_mem_we_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [7:0]        w_mem_wdata_nxt;
  logic              w_resp_valid_nxt, w_resp_err_nxt;
  logic [31:0]       w_resp_rdata_nxt;
  logic [31:0]       w_load_word, w_load_ext;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_ready && req_valid;
  assign w_req_err = (AU_inst_sel == 2'b11)
                  || (AU_inst_sel == SZ_WORD && req_addr[1:0] != 2'b00)
                  || (AU_inst_sel == SZ_HALF && req_addr[0]);
  assign w_idx_inc = r_idx + 2'd1;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_last_idx = 2'd0;
    case (r_size)
      SZ_WORD: w_last_idx = 2'd3;
      SZ_HALF: w_last_idx = 2'd1;
      default: w_last_idx = 2'd0;
    endcase
  end

  // The last read byte arrives on mem_rdata in the same cycle the response is formed.
  always_comb begin
    w_load_word = r_rdata;
    w_load_word[{r_cap_idx, 3'b000} +: 8] = mem_rdata;
    case (r_size)
      SZ_HALF: w_load_ext = r_signed ? {{16{w_load_word[15]}}, w_load_word[15:0]}
                                     : {16'h0000, w_load_word[15:0]};
      SZ_BYTE: w_load_ext = r_signed ? {{24{w_load_word[7]}}, w_load_word[7:0]}
                                     : {24'h000000, w_load_word[7:0]};
      default: w_load_ext = w_load_word;
    endcase
  end

  // Outputs are registered, so this process computes their values for the next cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_mem_en_nxt     = 1'b0;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = '0;
    w_mem_wdata_nxt  = 8'h00;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = resp_rdata;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = 32'h0;
          end else begin
            w_state_nxt     = req_write ? S_WRITE : S_READ;
            w_idx_nxt       = 2'd0;
            w_mem_en_nxt    = 1'b1;
            w_mem_we_nxt    = req_write;
            w_mem_addr_nxt  = req_addr;
            w_mem_wdata_nxt = req_write ? req_wdata[7:0] : 8'h00;
          end
        end
      end
      S_WRITE: begin
        if (r_idx == w_last_idx) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = 32'h0;
        end else begin
          w_idx_nxt       = w_idx_inc;
          w_mem_en_nxt    = 1'b1;
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = r_base + ADDR_W'(w_idx_inc);
          w_mem_wdata_nxt = r_wdata[{w_idx_inc, 3'b000} +: 8];
        end
      end
      S_READ: begin
        if (mem_en && r_idx != w_last_idx) begin
          w_idx_nxt      = w_idx_inc;
          w_mem_en_nxt   = 1'b1;
          w_mem_addr_nxt = r_base + ADDR_W'(w_idx_inc);
        end
        if (r_cap_en && r_cap_idx == w_last_idx) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = w_load_ext;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_base     <= '0;
      r_wdata    <= 32'h0;
      r_idx      <= 2'd0;
      r_cap_en   <= 1'b0;
      r_cap_idx  <= 2'd0;
      r_rdata    <= 32'h0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      mem_en     <= w_mem_en_nxt;
      mem_we     <= w_mem_we_nxt;
      mem_addr   <= w_mem_addr_nxt;
      mem_wdata  <= w_mem_wdata_nxt;
      resp_valid <= w_resp_valid_nxt;
      resp_err   <= w_resp_err_nxt;
      resp_rdata <= w_resp_rdata_nxt;
      // A read strobe this cycle means its byte is on mem_rdata next cycle.
      r_cap_en   <= mem_en && !mem_we;
      r_cap_idx  <= r_idx;
      if (w_accept) begin
        r_size   <= AU_inst_sel;
        r_signed <= signed_inst;
        r_base   <= req_addr;
        r_wdata  <= req_wdata;
        r_rdata  <= 32'h0;
      end else if (r_cap_en) begin
        r_rdata[{r_cap_idx, 3'b000} +: 8] <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory model, directed steps, then random
// requests compared against an array-based reference of memory and load results.
module tb_load_store_unit;
  localparam int ADDR_W = 6;
  localparam int MEM_SZ = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        AU_inst_sel = 2'b00;
  logic              signed_inst = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  int checks = 0;
  int failures = 0;
  int txn_count = 0;
  int resp_count = 0;

  logic [7:0] mem [MEM_SZ];
  logic [7:0] ref_mem [MEM_SZ];
  logic [7:0] init_bytes [MEM_SZ];
  logic       mem_init = 1'b1;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .AU_inst_sel(AU_inst_sel), .signed_inst(signed_inst),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous byte memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_SZ; i++) mem[i] <= init_bytes[i];
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  always @(posedge clk) if (!rst && resp_valid) resp_count++;

  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},      32'(req_ready),  32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_err"},   32'(resp_err),   32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    check({tag, "_mem_en"},     32'(mem_en),     32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
  endtask

  task automatic check_mem_image(input string tag);
    int diffs = 0;
    for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check(tag, diffs, 0);
  endtask

  // Issues one request (called at a negedge) and checks every cycle until the response.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sel,
                        input logic sgn, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wd, input bit hold, output logic [31:0] rd);
    bit          err, got;
    int          n, lat, waits, a;
    logic [31:0] exp_rd;
    err = (sel == 2'b11) || (sel == 2'b00 && addr[1:0] != 2'b00) || (sel == 2'b01 && addr[0]);
    n   = (sel == 2'b00) ? 4 : (sel == 2'b01) ? 2 : 1;
    lat = err ? 1 : (wr ? n + 1 : n + 2);
    exp_rd = 32'h0;
    if (!err && !wr) begin
      for (int i = 0; i < n; i++) exp_rd |= 32'(ref_mem[(int'(addr) + i) % MEM_SZ]) << (8 * i);
      if (sgn && n < 4 && exp_rd[8*n-1]) exp_rd |= 32'hFFFF_FFFF << (8 * n);
    end
    req_valid = 1'b1; req_write = wr; AU_inst_sel = sel; signed_inst = sgn;
    req_addr = addr; req_wdata = wd;
    waits = 0;
    while (!req_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    check({tag, "_ready_at_accept"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    txn_count++;
    if (hold) begin
      req_write = 1'($urandom); AU_inst_sel = 2'($urandom); signed_inst = 1'($urandom);
      req_addr = ADDR_W'($urandom); req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    got = 1'b0;
    for (int c = 1; c <= lat + 4 && !got; c++) begin
      @(negedge clk);
      check({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
      if (resp_valid) begin
        got = 1'b1;
        check({tag, "_latency"}, c, lat);
        check({tag, "_resp_err"}, 32'(resp_err), 32'(err));
        check({tag, "_resp_rdata"}, resp_rdata, exp_rd);
        check({tag, "_resp_mem_en"}, 32'(mem_en), 32'd0);
      end else if (!err && c <= n) begin
        a = (int'(addr) + c - 1) % MEM_SZ;
        check({tag, "_mem_en"}, 32'(mem_en), 32'd1);
        check({tag, "_mem_we"}, 32'(mem_we), 32'(wr));
        check({tag, "_mem_addr"}, 32'(mem_addr), a);
        if (wr) check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(wd[8*(c-1) +: 8]));
      end else begin
        check({tag, "_idle_mem_en"}, 32'(mem_en), 32'd0);
      end
    end
    check({tag, "_resp_seen"}, 32'(got), 32'd1);
    if (!err && wr)
      for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % MEM_SZ] = wd[8*i +: 8];
    rd = resp_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    for (int i = 0; i < MEM_SZ; i++) begin
      init_bytes[i] = 8'($urandom);
      ref_mem[i]    = init_bytes[i];
    end
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of an SW: byte 8 is already written, the rest never are.
    req_valid = 1'b1; req_write = 1'b1; AU_inst_sel = 2'b00; signed_inst = 1'b0;
    req_addr = 6'd8; req_wdata = 32'hA1B2_C3D4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midop_mem_en", 32'(mem_en), 32'd1);
    check("midop_mem_addr", 32'(mem_addr), 32'd9);
    rst = 1'b1;
    #1;
    check_idle_outputs("midop_async");
    @(posedge clk);
    #1;
    check_idle_outputs("midop_edge");
    ref_mem[8] = 8'hD4;
    @(negedge clk);
    rst = 1'b0;
    check_mem_image("midop_mem_image");

    do_req("sw4", 1'b1, 2'b00, 1'b0, 6'd4, 32'hDEAD_BEEF, 1'b0, rd);
    check("sw4_rdata_zero", rd, 32'h0);
    do_req("lw4", 1'b0, 2'b00, 1'b0, 6'd4, 32'h0, 1'b0, rd);
    check("lw4_const", rd, 32'hDEAD_BEEF);

    do_req("sb10", 1'b1, 2'b10, 1'b0, 6'd10, 32'h0000_0034, 1'b0, rd);
    do_req("sb11", 1'b1, 2'b10, 1'b0, 6'd11, 32'h0000_0085, 1'b0, rd);
    do_req("lh10", 1'b0, 2'b01, 1'b1, 6'd10, 32'h0, 1'b0, rd);
    check("lh10_const", rd, 32'hFFFF_8534);
    do_req("lhu10", 1'b0, 2'b01, 1'b0, 6'd10, 32'h0, 1'b0, rd);
    check("lhu10_const", rd, 32'h0000_8534);

    do_req("sb3", 1'b1, 2'b10, 1'b1, 6'd3, 32'h0000_0080, 1'b0, rd);
    do_req("lb3", 1'b0, 2'b10, 1'b1, 6'd3, 32'h0, 1'b0, rd);
    check("lb3_const", rd, 32'hFFFF_FF80);
    do_req("lbu3", 1'b0, 2'b10, 1'b0, 6'd3, 32'h0, 1'b0, rd);
    check("lbu3_const", rd, 32'h0000_0080);
    @(negedge clk);
    check("rdata_held", resp_rdata, 32'h0000_0080);
    check("pulse_one_cycle", 32'(resp_valid), 32'd0);
    do_req("sb3_7f", 1'b1, 2'b10, 1'b0, 6'd3, 32'h1234_567F, 1'b0, rd);
    check("sb3_7f_byte", 32'(mem[3]), 32'h7F);
    check_mem_image("sb3_mem_image");

    do_req("err_lw2", 1'b0, 2'b00, 1'b0, 6'd2, 32'h0, 1'b0, rd);
    do_req("err_sh5", 1'b1, 2'b01, 1'b0, 6'd5, 32'hFFFF_FFFF, 1'b0, rd);
    do_req("err_sel3", 1'b0, 2'b11, 1'b1, 6'd0, 32'h0, 1'b0, rd);
    do_req("err_sel3_st", 1'b1, 2'b11, 1'b0, 6'd12, 32'h1111_1111, 1'b0, rd);

    // Three requests with req_valid held high across the busy cycles.
    do_req("b2b_sw", 1'b1, 2'b00, 1'b0, 6'd20, 32'h0BAD_F00D, 1'b1, rd);
    do_req("b2b_lh", 1'b0, 2'b01, 1'b1, 6'd22, 32'h0, 1'b1, rd);
    check("b2b_lh_const", rd, 32'h0000_0BAD);
    do_req("b2b_lbu", 1'b0, 2'b10, 1'b0, 6'd21, 32'h0, 1'b0, rd);
    check("b2b_lbu_const", rd, 32'h0000_00F0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_quiet_mem_en", 32'(mem_en), 32'd0);
      check("b2b_quiet_resp", 32'(resp_valid), 32'd0);
    end

    for (int t = 0; t < 60; t++) begin
      logic [1:0]        sel;
      logic [ADDR_W-1:0] addr;
      sel  = 2'($urandom);
      addr = ADDR_W'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sel == 2'b00) addr[1:0] = 2'b00;
        if (sel == 2'b01) addr[0] = 1'b0;
      end
      do_req("rand", 1'($urandom), sel, 1'($urandom), addr, $urandom, 1'b0, rd);
    end

    @(negedge clk);
    check_mem_image("final_mem_image");
    check("resp_count", resp_count, txn_count);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface; sits between the core's execute/memory stage and a byte-wide synchronous data memory.
- Accepts one load or store request at a time (SW/SH/SB, LW/LH/LHU/LB/LBU) and serialises it into little-endian byte accesses, one per cycle.
- For loads, reassembles the bytes and zero- or sign-extends the result.
- Returns a single-cycle response pulse carrying load data or an alignment/encoding error.

Parameters:
- ADDR_W, 6: byte-address width; memory holds 2^ADDR_W bytes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- AU_inst_sel  in  2  access size: 00 word, 01 half, 10 byte, 11 illegal.
- signed_inst  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte base address.
- req_wdata  in  32  store data; low bytes used for half/byte.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualified by resp_valid; misaligned or illegal size.
- resp_rdata  out  32  load result; 0 for stores and errors; held until the next response.
- mem_en  out  1  memory access strobe this cycle.
- mem_we  out  1  1 = byte write, 0 = byte read; qualified by mem_en.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; valid the cycle after a read strobe (mem_en=1, mem_we=0).

Behaviour:
- Reset: asynchronous, active-high. Forces IDLE. All registered outputs are 0: resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata. req_ready=1 after reset.
- Reset mid-operation: aborts immediately. Bytes already written stay in memory; there is no rollback.
- Byte count n: 4 for 00, 2 for 01, 1 for 10.
- Byte ordering: byte i is at base+i and maps to data bits [8i+7:8i] (little-endian).
- Address arithmetic: base+i is computed modulo 2^ADDR_W.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1, mem_en=0.
  - On req_valid, latch all request fields.
  - Error condition: AU_inst_sel=11, or word with addr[1:0]≠0, or half with addr[0]≠0. Go to RESP with error flag set; no memory access is issued.
  - Otherwise go to WRITE (req_write=1) or READ (req_write=0); byte index = 0.
- WRITE:
  - Each cycle: mem_en=1, mem_we=1, mem_addr=base+idx, mem_wdata=byte idx of latched wdata.
  - After idx=n-1, go to RESP.
- READ:
  - Issue phase: cycles 1..n drive mem_en=1, mem_we=0, mem_addr=base+issue_idx.
  - Capture phase: mem_rdata is captured into byte lane capture_idx one cycle after each issue, i.e. cycles 2..n+1.
  - One drain cycle after the last issue has mem_en=0.
  - After the last capture, go to RESP.
- Extension on loads: signed_inst=1 replicates bit 15 (half) or bit 7 (byte) into the upper bits; signed_inst=0 zero-fills. Word loads are not extended.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_err = error flag.
  - resp_rdata = extended load data, or 0 for stores and errors.
  - Next state: IDLE.
- Latency, counted from the accept edge as cycle 0:
  - Store: resp_valid in cycle n+1.
  - Load: resp_valid in cycle n+2.
  - Error: resp_valid in cycle 1.
- Back-to-back: a new request can be accepted in the cycle after RESP.
- req_valid outside IDLE is ignored; req_ready=0 in all non-IDLE states.
- signed_inst is ignored on stores.
- mem_en is never asserted in IDLE or RESP.

Test Plan:
- Reset mid-op: assert rst during WRITE of an SW to addr 8 → next edge shows IDLE and req_ready=1 with all listed outputs 0; partially written bytes stay in memory.
- SW then LW: SW addr 4, data 0xDEADBEEF → writes 0xEF,0xBE,0xAD,0xDE to addrs 4..7 in cycles 1..4, resp_valid in cycle 5 with resp_rdata=0. LW addr 4 → resp_valid in cycle 6 with resp_rdata=0xDEADBEEF, resp_err=0.
- Half loads: memory bytes addr 10=0x34, 11=0x85. LH addr 10 → 0xFFFF8534. LHU addr 10 → 0x00008534.
- Byte loads: memory byte addr 3=0x80. LB addr 3 → 0xFFFFFF80. LBU addr 3 → 0x00000080. SB addr 3, data 0x1234567F → only addr 3 written with 0x7F.
- Errors: LW addr 2, SH addr 5, and AU_inst_sel=11 each → resp_valid in cycle 1 with resp_err=1, resp_rdata=0, and mem_en never asserted.
- Back-to-back with busy-time requests: hold req_valid high throughout three consecutive requests → req_ready low outside IDLE, each request accepted exactly once, responses in issue order.
